// File: rtl/sar_search.sv
// Successive-approximation search controller driving the B operand of an external comparator.
// Optional macro SAR_EARLY_EXIT_EN: a sampled eq ends the search immediately.
module sar_search #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             eq,
    input  logic             a_more,
    input  logic             b_more,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] bit_k;
    logic [WIDTH-1:0] next_res;
    logic             onehot;
    logic             last;

    always_comb begin
        bit_k    = WIDTH'(1) << k;
        onehot   = ({eq, a_more, b_more} == 3'b100) ||
                   ({eq, a_more, b_more} == 3'b010) ||
                   ({eq, a_more, b_more} == 3'b001);
        next_res = (eq || a_more) ? (result | bit_k) : result;
        last     = (k == '0);
`ifdef SAR_EARLY_EXIT_EN
        if (eq) last = 1'b1;
`endif
    end

    // guess is registered, so each transition loads the value the next state must present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            k      <= KW'(WIDTH - 1);
            guess  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= PROBE;
                        k      <= KW'(WIDTH - 1);
                        result <= '0;
                        found  <= 1'b0;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        guess  <= WIDTH'(1) << (WIDTH - 1);
                    end else begin
                        state <= IDLE;
                        done  <= 1'b0;
                        guess <= result;
                    end
                end
                PROBE: begin
                    if (!onehot) begin
                        err   <= 1'b1;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        guess <= result;
                    end else begin
                        result <= next_res;
                        if (eq) found <= 1'b1;
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            guess <= next_res;
                        end else begin
                            k     <= k - KW'(1);
                            guess <= next_res | (bit_k >> 1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Directed self-checking bench for sar_search (WIDTH=3) with a behavioural comparator attached.
module tb_sar_search;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       eq, a_more, b_more;
    logic [2:0] guess, result;
    logic       busy, done, found, err;

    logic [2:0] target = 3'd0;
    logic       ovr_en = 1'b0;
    logic [2:0] ovr_val = 3'b000;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign {eq, a_more, b_more} = ovr_en ? ovr_val :
                                  {guess == target, target > guess, guess > target};

    sar_search #(.WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .eq(eq), .a_more(a_more), .b_more(b_more),
        .guess(guess), .busy(busy), .done(done),
        .result(result), .found(found), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single start pulse, then np probes with expected guesses packed lowest-first in gl.
    task automatic search(input string tag, input logic [2:0] tgt, input int np,
                          input logic [8:0] gl, input logic [2:0] res,
                          input logic f, input logic e);
        target = tgt;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int i = 0; i < np; i++) begin
            chk({tag, "_guess"}, guess, gl[3*i +: 3]);
            chk({tag, "_busy"}, busy, 1'b1);
            step();
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy_done"}, busy, 1'b0);
        chk({tag, "_result"}, result, res);
        chk({tag, "_found"}, found, f);
        chk({tag, "_err"}, err, e);
        chk({tag, "_guess_done"}, guess, res);
        step();
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_result_held"}, result, res);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("rst_guess", guess, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 3'd0);
        chk("rst_flags", {found, err}, 2'b00);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 1'b0);

        // guesses 4, 6, 5
        search("t5", 3'd5, 3, {3'd5, 3'd6, 3'd4}, 3'd5, 1'b1, 1'b0);
`ifdef SAR_EARLY_EXIT_EN
        search("t4", 3'd4, 1, {3'd0, 3'd0, 3'd4}, 3'd4, 1'b1, 1'b0);
`else
        // after eq at 4 the remaining probes 6, 5 answer b_more
        search("t4", 3'd4, 3, {3'd5, 3'd6, 3'd4}, 3'd4, 1'b1, 1'b0);
`endif
        search("t0", 3'd0, 3, {3'd1, 3'd2, 3'd4}, 3'd0, 1'b0, 1'b0);
        search("t7", 3'd7, 3, {3'd7, 3'd6, 3'd4}, 3'd7, 1'b1, 1'b0);

        // Bad flags on the second probe: abort with the first-probe bit only.
        target = 3'd5;
        start  = 1'b1;
        step();
        start  = 1'b0;
        chk("err_g1", guess, 3'd4);
        step();
        chk("err_g2", guess, 3'd6);
        ovr_en  = 1'b1;
        ovr_val = 3'b011;
        step();
        ovr_en  = 1'b0;
        chk("err_done", done, 1'b1);
        chk("err_err", err, 1'b1);
        chk("err_result", result, 3'd4);
        chk("err_found", found, 1'b0);
        step();
        chk("err_idle", {done, busy}, 2'b00);

        // Asynchronous reset mid-search.
        target = 3'd5;
        start  = 1'b1;
        step();
        start  = 1'b0;
        step();
        chk("rstm_pre", result, 3'd4);
        rst_n = 1'b0;
        #1;
        chk("rstm_guess", guess, 3'd0);
        chk("rstm_result", result, 3'd0);
        chk("rstm_busy", busy, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        chk("rstm_idle", {busy, done, found, err}, 4'b0000);

        // start pulse during PROBE is ignored; target 3 -> guesses 4, 2, 3.
        target = 3'd3;
        start  = 1'b1;
        step();
        start  = 1'b0;
        chk("ign_g1", guess, 3'd4);
        step();
        chk("ign_g2", guess, 3'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_g3", guess, 3'd3);
        step();
        chk("ign_done", done, 1'b1);
        chk("ign_result", result, 3'd3);
        step();
        chk("ign_idle", {busy, done}, 2'b00);

        // start held high through DONE: no gap between searches.
        target = 3'd5;
        start  = 1'b1;
        step();
        chk("b2b_g1", guess, 3'd4);
        step();
        step();
        chk("b2b_g3", guess, 3'd5);
        step();
        chk("b2b_done", done, 1'b1);
        chk("b2b_res1", result, 3'd5);
        target = 3'd3;
        step();
        start = 1'b0;
        chk("b2b_restart_busy", busy, 1'b1);
        chk("b2b_restart_guess", guess, 3'd4);
        chk("b2b_restart_clr", result, 3'd0);
        step();
        step();
        step();
        chk("b2b_done2", done, 1'b1);
        chk("b2b_res2", result, 3'd3);
        chk("b2b_found2", found, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
